// File: rtl/msg_assembler.sv
// msg_assembler: packs a byte-serial valid/ready stream into a held {msg, length} word.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid/i_data/i_last   upstream byte beat; o_ready accepts it (high only in FILL)
//   o_msg, o_length         packed message (first character in the MSBs) and stored count
//   o_msg_valid             high exactly while the message is held for the consumer
//   i_msg_ready             consumer release; clears the message and returns to FILL
//   o_truncated             message carried more than MESSAGE_LENGTH bytes
// Optional: define MSG_ASSEMBLER_CASE_FOLD_EN to fold A-Z to lowercase before storage.
module msg_assembler #(
    parameter int MESSAGE_LENGTH = 200,
    parameter int CHAR_LENGTH    = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_valid,
    input  logic [CHAR_LENGTH-1:0]                i_data,
    input  logic                                  i_last,
    output logic                                  o_ready,
    output logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] o_msg,
    output logic [LEN_WIDTH-1:0]                  o_length,
    output logic                                  o_msg_valid,
    input  logic                                  i_msg_ready,
    output logic                                  o_truncated
);
    localparam int MW = CHAR_LENGTH * MESSAGE_LENGTH;
    localparam int IW = $clog2(MW);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [MW-1:0]          r_msg;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_trunc;
    logic                   w_accept;
    logic                   w_full;
    logic                   w_release;
    logic [CHAR_LENGTH-1:0] w_char;
    logic [IW-1:0]          w_base;

    assign w_accept  = i_valid && r_state == FILL;
    assign w_release = i_msg_ready && r_state == HOLD;
    assign w_full    = r_len == LEN_WIDTH'(MESSAGE_LENGTH);
    // Slot i sits at the top of the vector, descending; only used while not full.
    assign w_base    = IW'(CHAR_LENGTH * (MESSAGE_LENGTH - 1 - int'(r_len)));

`ifdef MSG_ASSEMBLER_CASE_FOLD_EN
    assign w_char = (i_data >= CHAR_LENGTH'(8'h41) && i_data <= CHAR_LENGTH'(8'h5A))
                    ? (i_data | CHAR_LENGTH'(8'h20)) : i_data;
`else
    assign w_char = i_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= FILL;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == FILL && w_accept && i_last) w_next_state = HOLD;
        if (w_release) w_next_state = FILL;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || w_release) begin
            r_msg   <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (w_accept) begin
            // A full message drops further bytes and only flags truncation.
            if (w_full) begin
                r_trunc <= 1'b1;
            end else begin
                r_msg[w_base +: CHAR_LENGTH] <= w_char;
                r_len                        <= r_len + 1'b1;
            end
        end
    end

    assign o_ready     = r_state == FILL;
    assign o_msg_valid = r_state == HOLD;
    assign o_msg       = r_msg;
    assign o_length    = r_len;
    assign o_truncated = r_trunc;
endmodule

// File: tb/tb_msg_assembler.sv
// tb_msg_assembler: randomized self-checking bench for msg_assembler against a queue model.
module tb_msg_assembler;
    localparam int ML = 200;
    localparam int CW = 8;
    localparam int MW = ML * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [CW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_ready;
    logic [MW-1:0] o_msg;
    logic [7:0]    o_length;
    logic          o_msg_valid;
    logic          i_msg_ready = 1'b0;
    logic          o_truncated;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int n_sent = 0;

    msg_assembler #(.MESSAGE_LENGTH(ML), .CHAR_LENGTH(CW), .LEN_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .o_ready(o_ready), .o_msg(o_msg), .o_length(o_length), .o_msg_valid(o_msg_valid),
        .i_msg_ready(i_msg_ready), .o_truncated(o_truncated)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef MSG_ASSEMBLER_CASE_FOLD_EN
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
        return b;
`endif
    endfunction

    // Expected message: stored characters concatenated from the top, zeros below.
    function automatic logic [MW-1:0] exp_msg();
        logic [MW-1:0] v = '0;
        for (int i = 0; i < exp_q.size(); i++) v = v | (MW'(exp_q[i]) << (CW * (ML - 1 - i)));
        return v;
    endfunction

    function automatic logic [7:0] exp_len();
        return 8'(exp_q.size());
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        i_valid = 1'b1; i_data = d; i_last = last;
        while (!o_ready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL ready_timeout: o_ready=%0b required 1", o_ready);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0; i_data = 'x;
        n_sent++;
        if (exp_q.size() < ML) exp_q.push_back(fold(d));
    endtask

    task automatic release_msg();
        @(negedge clk); i_msg_ready = 1'b1;
        @(posedge clk); #1; i_msg_ready = 1'b0;
        exp_q.delete(); n_sent = 0;
        checks++;
        if (o_msg_valid !== 1'b0 || o_length !== 8'd0 || o_msg !== '0 || o_ready !== 1'b1 || o_truncated !== 1'b0) begin
            errors++;
            $display("FAIL release: valid=%0b len=%0d msg_zero=%0b ready=%0b trunc=%0b required 0 0 1 1 0",
                     o_msg_valid, o_length, o_msg == '0, o_ready, o_truncated);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (o_msg_valid !== 1'b0 || o_length !== 8'd0 || o_msg !== '0 || o_truncated !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: valid=%0b len=%0d trunc=%0b required 0 0 0", o_msg_valid, o_length, o_truncated);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_ready !== 1'b1 || o_msg_valid !== 1'b0 || o_length !== 8'd0 || o_msg !== '0 || o_truncated !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b valid=%0b len=%0d trunc=%0b required 1 0 0 0",
                     o_ready, o_msg_valid, o_length, o_truncated);
        end
    endtask

    task automatic test_short();
        logic [MW-1:0] e;
        send_byte(8'h68, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h6D, 1'b1);
        e = exp_msg();
        checks++;
        if (o_msg_valid !== 1'b1 || o_length !== 8'd3 || o_ready !== 1'b0 || o_msg[MW-1 -: 24] !== 24'h68616D || o_msg !== e) begin
            errors++;
            $display("FAIL short_msg: valid=%0b len=%0d ready=%0b top=%h required 1 3 0 68616d",
                     o_msg_valid, o_length, o_ready, o_msg[MW-1 -: 24]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_data = 8'($urandom); i_last = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (o_msg !== e || o_length !== 8'd3 || o_msg_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: len=%0d valid=%0b top=%h required 3 1 68616d",
                         o_length, o_msg_valid, o_msg[MW-1 -: 24]);
            end
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_back_to_back();
        release_msg();
        send_byte(8'h41, 1'b1);
        checks++;
        if (o_length !== 8'd1 || o_msg_valid !== 1'b1 || o_msg[MW-1 -: 8] !== fold(8'h41) || o_msg !== exp_msg()) begin
            errors++;
            $display("FAIL single_byte: len=%0d valid=%0b top=%h required 1 1 %h",
                     o_length, o_msg_valid, o_msg[MW-1 -: 8], fold(8'h41));
        end
        release_msg();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 205; i++) begin
            send_byte(8'h78, 1'(i == 204));
            if (i == 199 || i == 200) begin
                checks++;
                if (o_length !== 8'd200 || o_truncated !== 1'(i == 200) || o_msg_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_edge%0d: len=%0d trunc=%0b valid=%0b required 200 %0b 0",
                             i, o_length, o_truncated, o_msg_valid, i == 200);
                end
            end
        end
        checks++;
        if (o_length !== 8'd200 || o_truncated !== 1'b1 || o_msg_valid !== 1'b1 || o_msg !== {ML{8'h78}}) begin
            errors++;
            $display("FAIL overflow: len=%0d trunc=%0b valid=%0b low=%h required 200 1 1 78",
                     o_length, o_truncated, o_msg_valid, o_msg[7:0]);
        end
        release_msg();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom_range(32, 126)), 1'(i == 3));
            if (i < 3) begin
                @(negedge clk); i_valid = 1'b0; i_data = 8'hFF;
                @(posedge clk); #1;
                checks++;
                if (o_length !== exp_len() || o_msg !== exp_msg()) begin
                    errors++;
                    $display("FAIL stall_idle%0d: len=%0d required %0d", i, o_length, exp_len());
                end
            end
        end
        checks++;
        if (o_length !== 8'd4 || o_msg !== exp_msg() || o_msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall: len=%0d valid=%0b top=%h required 4 1 %h",
                     o_length, o_msg_valid, o_msg[MW-1 -: 32], exp_msg() >> (MW - 32));
        end
        release_msg();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_length !== 8'd0 || o_msg !== '0 || o_msg_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: len=%0d valid=%0b ready=%0b required 0 0 1", o_length, o_msg_valid, o_ready);
        end
        exp_q.delete(); n_sent = 0;
        @(negedge clk); rst_n = 1'b1;
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        checks++;
        if (o_length !== 8'd2 || o_msg !== exp_msg() || o_msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: len=%0d valid=%0b required 2 1", o_length, o_msg_valid);
        end
        release_msg();
    endtask

    task automatic test_random();
        for (int m = 0; m < 6; m++) begin
            int n = $urandom_range(1, 210);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = ($urandom % 2) ? 8'($urandom_range(8'h3F, 8'h5C)) : 8'($urandom);
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    i_valid = 1'b0; i_data = 8'($urandom); i_msg_ready = 1'($urandom);
                end
                @(negedge clk); i_msg_ready = 1'b0;
                send_byte(b, 1'(i == n - 1));
            end
            checks++;
            if (o_msg_valid !== 1'b1 || o_length !== exp_len() || o_truncated !== 1'(n_sent > ML) || o_msg !== exp_msg()) begin
                errors++;
                $display("FAIL random%0d: valid=%0b len=%0d trunc=%0b top=%h required 1 %0d %0b %h",
                         m, o_msg_valid, o_length, o_truncated, o_msg[MW-1 -: 64], exp_len(), n_sent > ML,
                         exp_msg() >> (MW - 64));
            end
            release_msg();
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
